// File: rtl/systolic_output_collector.sv
// systolic_output_collector: deskews the two bottom-edge columns of a 2x2 systolic array into rows on a valid/ready stream.
// Define COLLECTOR_RELU_EN to clamp negative elements to zero as they are popped.
module systolic_output_collector #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int ROW_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ROW_W-1:0]    num_rows,
   input  logic [DATA_W-1:0]   col_data_1,
   input  logic                col_valid_1,
   input  logic [DATA_W-1:0]   col_data_2,
   input  logic                col_valid_2,
   output logic [2*DATA_W-1:0] out_row_data,
   output logic [ROW_W-1:0]    out_row_idx,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                done,
   output logic                overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, FINISH = 2'd2;
   logic [1:0] state_q, state_d;
   logic [ROW_W-1:0] num_q, emit_q, out_idx_q;
   logic [2*DATA_W-1:0] out_data_q;
   logic out_valid_q, ovf_q, collect, start_ok, last_hs, pop;
   logic [1:0][DATA_W-1:0] in_data, head;
   logic [1:0] in_valid, elig, avail, acc, wr, rd, ovf;

   function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
`ifdef COLLECTOR_RELU_EN
      return x[DATA_W-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   assign in_data  = {col_data_2, col_data_1};
   assign in_valid = {col_valid_2, col_valid_1};
   assign collect  = state_q == COLLECT;
   assign start_ok = start && state_q == IDLE;
   assign last_hs  = collect && out_valid_q && out_ready && out_idx_q == num_q - 1'b1;
   // An empty FIFO forwards this cycle's strobe straight to the output register.
   assign pop      = collect && &avail && (!out_valid_q || out_ready);

   genvar c;
   for (c = 0; c < 2; c++) begin : g_col
      logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
      logic [AW-1:0] wp_q, rp_q;
      logic [AW:0] cnt_q;
      logic [ROW_W-1:0] pcnt_q;
      logic empty, full;
      assign empty    = cnt_q == '0;
      assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
      assign elig[c]  = collect && in_valid[c] && pcnt_q < num_q;
      assign avail[c] = !empty || elig[c];
      assign acc[c]   = elig[c] && (!full || pop);
      assign wr[c]    = acc[c] && !(empty && pop);
      assign rd[c]    = pop && !empty;
      assign head[c]  = empty ? in_data[c] : mem_q[rp_q];
      assign ovf[c]   = collect && in_valid[c] && !acc[c];
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            pcnt_q <= '0;
         end else if (start_ok) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            pcnt_q <= '0;
         end else begin
            if (wr[c]) wp_q <= wp_q + 1'b1;
            if (rd[c]) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(wr[c]) - (AW+1)'(rd[c]);
            if (acc[c]) pcnt_q <= pcnt_q + 1'b1;
         end
      always_ff @(posedge clk)
         if (wr[c]) mem_q[wp_q] <= in_data[c];
   end

   always_comb
      state_d = start_ok ? (num_rows != '0 ? COLLECT : FINISH) :
                last_hs ? FINISH :
                state_q == FINISH ? IDLE : state_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         num_q       <= '0;
         emit_q      <= '0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            num_q  <= num_rows;
            emit_q <= '0;
            ovf_q  <= 1'b0;
         end else if (|ovf) ovf_q <= 1'b1;
         if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {relu(head[1]), relu(head[0])};
            out_idx_q   <= emit_q;
            emit_q      <= emit_q + 1'b1;
         end else if (out_ready) out_valid_q <= 1'b0;
      end

   assign out_row_data = out_data_q;
   assign out_row_idx  = out_idx_q;
   assign out_valid    = out_valid_q;
   assign busy         = collect;
   assign done         = state_q == FINISH;
   assign overflow     = ovf_q;
endmodule

// File: tb/tb_systolic_output_collector.sv
// tb_systolic_output_collector: scoreboard bench for the column deskew collector with a queue-based row model.
module tb_systolic_output_collector;
   localparam int DW = 16, FD = 4, RW = 8;
   logic clk = 0, rst = 1, start = 0, c1v = 0, c2v = 0, out_ready = 0;
   logic [RW-1:0] num_rows = '0;
   logic [DW-1:0] c1d = '0, c2d = '0;
   logic [2*DW-1:0] out_row_data;
   logic [RW-1:0] out_row_idx;
   logic out_valid, busy, done, overflow;
   int checks = 0, failures = 0;
   int cyc_n = 0, done_at = -1, accepted = 0, m_num = 0, m_cnt1 = 0, m_cnt2 = 0, m_idx = 0;
   bit m_collect = 0, exp_ovf = 0, saw_done = 0;
   typedef struct packed {logic [2*DW-1:0] d; logic [RW-1:0] i;} row_t;
   row_t exp_q[$];
   logic [DW-1:0] q1[$], q2[$];
   logic [DW-1:0] s1[4], s2[4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   systolic_output_collector #(.DATA_W(DW), .FIFO_DEPTH(FD), .ROW_W(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
      .col_data_1(c1d), .col_valid_1(c1v), .col_data_2(c2d), .col_valid_2(c2v),
      .out_row_data(out_row_data), .out_row_idx(out_row_idx), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc_n);
      end
   endtask

   function automatic logic [DW-1:0] m_relu(input logic [DW-1:0] x);
`ifdef COLLECTOR_RELU_EN
      return x[DW-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   // Monitor: compares every accepted row against the scoreboard and tracks done/hold behaviour.
   initial begin
      row_t r;
      bit stall = 0;
      logic [2*DW-1:0] hd;
      logic [RW-1:0] hi;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 0;
            continue;
         end
         chk("done", done, 64'(cyc_n == done_at));
         if (done) saw_done = 1;
         if (stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_row_data, hd);
            chk("hold_idx", out_row_idx, hi);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_row", out_valid, 0);
            else begin
               r = exp_q.pop_front();
               chk("row_data", out_row_data, r.d);
               chk("row_idx", out_row_idx, r.i);
            end
            accepted++;
            if (accepted == m_num) begin
               done_at = cyc_n + 1;
               m_collect = 0;
            end
         end
         stall = out_valid && !out_ready;
         hd = out_row_data;
         hi = out_row_idx;
      end
   end

   task automatic cyc(input bit v1, input logic [DW-1:0] d1, input bit v2, input logic [DW-1:0] d2, input bit rdy);
      row_t r;
      logic [DW-1:0] a, b;
      c1v = v1; c1d = d1; c2v = v2; c2d = d2; out_ready = rdy;
      if (m_collect) begin
         if (v1) begin
            if (m_cnt1 < m_num) begin q1.push_back(d1); m_cnt1++; end
            else exp_ovf = 1;
         end
         if (v2) begin
            if (m_cnt2 < m_num) begin q2.push_back(d2); m_cnt2++; end
            else exp_ovf = 1;
         end
         while (q1.size() > 0 && q2.size() > 0) begin
            a = q1.pop_front();
            b = q2.pop_front();
            r.d = {m_relu(b), m_relu(a)};
            r.i = RW'(m_idx);
            exp_q.push_back(r);
            m_idx++;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_start(input int n);
      c1v = 0; c2v = 0;
      num_rows = RW'(n); start = 1;
      m_num = n; m_cnt1 = 0; m_cnt2 = 0; m_idx = 0; accepted = 0;
      exp_ovf = 0; saw_done = 0; q1.delete(); q2.delete();
      m_collect = n != 0;
      if (n == 0) done_at = cyc_n + 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic wait_done();
      c1v = 0; c2v = 0; out_ready = 1;
      for (int i = 0; i < 300 && !saw_done; i++) @(posedge clk);
      #1;
      chk("job_done_seen", saw_done, 1);
      chk("busy_after_job", busy, 0);
   endtask

   // Column 2 trails column 1 by one cycle; out_ready is low for cycles [sf, sf+sl).
   task automatic stream(input int len, input int sf, input int sl);
      for (int i = 0; i <= len; i++) begin
         cyc(i < len, i < len ? s1[i] : '0, i > 0, i > 0 ? s2[i-1] : '0, !(i >= sf && i < sf + sl));
         if (i == 0) chk("no_early_valid", out_valid, 0);
         if (i == 1) chk("latency_valid", out_valid, 1);
      end
      c1v = 0; c2v = 0;
   endtask

   task automatic rand_job(input int n);
      int p1 = 0;
      bit pv = 0, v;
      logic [DW-1:0] pd = '0, d1, d2;
      do_start(n);
      while (p1 < n || pv) begin
         v = p1 < n && p1 - accepted < FD && $urandom_range(0, 3) != 0;
         d1 = DW'($urandom);
         d2 = DW'($urandom);
         cyc(v, d1, pv, pd, $urandom_range(0, 3) != 0);
         pv = v;
         pd = d2;
         if (v) p1++;
      end
      wait_done();
      chk("rand_overflow", overflow, 0);
      chk("rand_all_rows", 64'(exp_q.size()), 0);
   endtask

   initial begin
      logic [2*DW-1:0] relu_exp;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_row_data, 0);
      chk("rst_idx", out_row_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      repeat (2) @(posedge clk);
      #1; rst = 0;
      s1 = '{16'h0100, 16'h0300, 16'h0500, 16'h0700};
      s2 = '{16'h0200, 16'h0400, 16'h0600, 16'h0800};
      do_start(4);
      chk("busy_collect", busy, 1);
      stream(4, 99, 0);
      wait_done();
      chk("identity_ovf", overflow, 0);
      do_start(4);
      stream(4, 2, 3);
      wait_done();
      chk("stall_ovf", overflow, 0);
      do_start(2);
      stream(3, 99, 0);
      wait_done();
      chk("ovf_set", overflow, 64'(exp_ovf));
      repeat (3) cyc(0, '0, 0, '0, 1);
      chk("ovf_sticky", overflow, 1);
      do_start(0);
      chk("zero_rows_ovf_clear", overflow, 0);
      chk("zero_rows_busy", busy, 0);
      chk("zero_rows_valid", out_valid, 0);
      wait_done();
      repeat (3) cyc(1, 16'h1234, 1, 16'h5678, 1);
      chk("idle_no_ovf", overflow, 0);
      chk("idle_no_valid", out_valid, 0);
      do_start(4);
      stream(3, 0, 99);
      chk("pre_rst_valid", out_valid, 1);
      #2 rst = 1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_row_data, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      exp_q.delete(); q1.delete(); q2.delete();
      m_collect = 0; done_at = -1;
      @(posedge clk); #1;
      rst = 0;
      s1 = '{16'h0011, 16'h0033, 16'h0055, 16'h0077};
      s2 = '{16'h0022, 16'h0044, 16'h0066, 16'h0088};
      do_start(4);
      stream(4, 99, 0);
      wait_done();
      chk("fresh_ovf", overflow, 0);
      s1[0] = 16'hFF80;
      s2[0] = 16'h0080;
`ifdef COLLECTOR_RELU_EN
      relu_exp = 32'h0080_0000;
`else
      relu_exp = 32'h0080_FF80;
`endif
      do_start(1);
      cyc(1, s1[0], 0, '0, 1);
      cyc(0, '0, 1, s2[0], 1);
      chk("relu_row", out_row_data, relu_exp);
      wait_done();
      for (int j = 0; j < 8; j++) rand_job($urandom_range(1, 12));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
